// File: rtl/sram_responder_pkg.sv
// Shared definitions for the SRAM responder: MMIO register offsets, kseg address
// translation and byte-lane merging.
package sram_responder_pkg;

   localparam logic [15:0] MMIO_LED     = 16'h0000;
   localparam logic [15:0] MMIO_SWITCH  = 16'h0004;
   localparam logic [15:0] MMIO_TIMER   = 16'h0008;
   localparam logic [15:0] MMIO_SCRATCH = 16'h000C;

   // kseg0 (3'b100) and kseg1 (3'b101) both fold onto the low 512 MB.
   function automatic logic [31:0] kseg_xlate(input logic [31:0] vaddr);
      if (vaddr[31:30] == 2'b10) return {3'b000, vaddr[28:0]};
      return vaddr;
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wen);
      logic [31:0] word;
      word = old_word;
      for (int i = 0; i < 4; i++) begin
         if (wen[i]) word[8*i +: 8] = wdata[8*i +: 8];
      end
      return word;
   endfunction

endpackage

// File: rtl/sram_resp_mmio.sv
// MMIO register window of the data port: LED, switch readback, free-running
// timer and scratch, with a registered read mux.
module sram_resp_mmio
   import sram_responder_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        acc_en_i,
   input  logic [3:0]  wen_i,
   input  logic [15:0] offset_i,
   input  logic [31:0] wdata_i,
   input  logic [7:0]  switch_i,
   output logic [15:0] led_o,
   output logic [31:0] rdata_o
);

   logic [15:0] led_q;
   logic [31:0] timer_q;
   logic [31:0] scratch_q;
   logic [31:0] rdata_q;
   logic [31:0] rdata_d;
   logic        wr_en;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path infers a latch.
      rdata_d = '0;
      wr_en   = acc_en_i && (wen_i != 4'b0000);
      case (offset_i)
         MMIO_LED:     rdata_d = {16'h0000, led_q};
         MMIO_SWITCH:  rdata_d = {24'h000000, switch_i};
         MMIO_TIMER:   rdata_d = timer_q;
         MMIO_SCRATCH: rdata_d = scratch_q;
         default:      rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_q     <= '0;
         timer_q   <= '0;
         scratch_q <= '0;
         rdata_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments; the later one wins,
         // which lets a TIMER write override the increment in the same cycle.
         timer_q <= timer_q + 32'd1;
         if (wr_en) begin
            case (offset_i)
               MMIO_LED: begin
                  if (wen_i[0]) led_q[7:0]  <= wdata_i[7:0];
                  if (wen_i[1]) led_q[15:8] <= wdata_i[15:8];
               end
               MMIO_TIMER:   timer_q   <= merge_bytes(timer_q, wdata_i, wen_i);
               MMIO_SCRATCH: scratch_q <= merge_bytes(scratch_q, wdata_i, wen_i);
               default: ;
            endcase
         end
         if (acc_en_i) rdata_q <= rdata_d;
      end
   end

   assign led_o   = led_q;
   assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Slave side of the core's instruction/data SRAM ports: one shared byte-writable
// RAM, read-first with 1-cycle latency, plus an MMIO window on the data port.
module sram_responder
   import sram_responder_pkg::*;
#(
   parameter int          ADDR_W    = 14,
   parameter logic [31:0] MMIO_BASE = 32'h1FAF_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_sram_en,
   input  logic [3:0]  inst_sram_wen,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   input  logic [7:0]  switch
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0]       mem [0:DEPTH-1];
   logic [31:0]       data_phys;
   logic              data_is_mmio;
   logic [ADDR_W-1:0] data_idx;
   logic [ADDR_W-1:0] inst_idx;
   logic [3:0]        inst_we;
   logic [3:0]        data_we;
   logic [31:0]       inst_word;
   logic [31:0]       data_base;
   logic [31:0]       data_word;

   logic [31:0]       inst_rdata_q;
   logic [31:0]       data_ram_q;
   logic              data_sel_mmio_q;
   logic [31:0]       mmio_rdata;

   always_comb begin
      data_phys    = kseg_xlate(data_sram_addr);
      data_is_mmio = (data_phys[31:16] == MMIO_BASE[31:16]);
      data_idx     = data_phys[ADDR_W+1:2];
      inst_idx     = ADDR_W'(kseg_xlate(inst_sram_addr) >> 2);
      inst_we      = inst_sram_en ? inst_sram_wen : 4'b0000;
      data_we      = (data_sram_en && !data_is_mmio) ? data_sram_wen : 4'b0000;
      // Same-word collisions: data lanes are layered over the instruction merge.
      inst_word    = merge_bytes(mem[inst_idx], inst_sram_wdata, inst_we);
      data_base    = (inst_idx == data_idx) ? inst_word : mem[data_idx];
      data_word    = merge_bytes(data_base, data_sram_wdata, data_we);
   end

   // NOTE: the RAM array is deliberately not reset; only the read pipelines are.
   always_ff @(posedge clk) begin
      if (inst_we != 4'b0000) mem[inst_idx] <= inst_word;
      if (data_we != 4'b0000) mem[data_idx] <= data_word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inst_rdata_q    <= '0;
         data_ram_q      <= '0;
         data_sel_mmio_q <= 1'b0;
      end else begin
         if (inst_sram_en) inst_rdata_q <= mem[inst_idx];
         if (data_sram_en) begin
            data_sel_mmio_q <= data_is_mmio;
            if (!data_is_mmio) data_ram_q <= mem[data_idx];
         end
      end
   end

   sram_resp_mmio u_mmio (
      .clk      (clk),
      .rst      (rst),
      .acc_en_i (data_sram_en && data_is_mmio),
      .wen_i    (data_sram_wen),
      .offset_i (data_phys[15:0]),
      .wdata_i  (data_sram_wdata),
      .switch_i (switch),
      .led_o    (led),
      .rdata_o  (mmio_rdata)
   );

   assign inst_sram_rdata = inst_rdata_q;
   assign data_sram_rdata = data_sel_mmio_q ? mmio_rdata : data_ram_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed self-checking bench for sram_responder: RAM ports, collisions,
// aliasing, MMIO registers and reset behaviour.
module tb_sram_responder;

   logic        clk;
   logic        rst;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic [15:0] led;
   logic [7:0]  switch;

   int pass_cnt  = 0;
   int total_cnt = 0;

   sram_responder dut (
      .clk             (clk),
      .rst             (rst),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_wen   (inst_sram_wen),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata),
      .inst_sram_rdata (inst_sram_rdata),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .led             (led),
      .switch          (switch)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic data_wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wen);
      data_sram_en    = 1'b1;
      data_sram_wen   = wen;
      data_sram_addr  = addr;
      data_sram_wdata = wdata;
      tick();
      data_sram_en  = 1'b0;
      data_sram_wen = 4'b0000;
   endtask

   task automatic data_rd(input logic [31:0] addr);
      data_sram_en   = 1'b1;
      data_sram_wen  = 4'b0000;
      data_sram_addr = addr;
      tick();
      data_sram_en = 1'b0;
   endtask

   task automatic inst_rd(input logic [31:0] addr);
      inst_sram_en   = 1'b1;
      inst_sram_wen  = 4'b0000;
      inst_sram_addr = addr;
      tick();
      inst_sram_en = 1'b0;
   endtask

   initial begin
      logic [31:0] t0;
      rst             = 1'b1;
      inst_sram_en    = 1'b0;
      inst_sram_wen   = 4'b0000;
      inst_sram_addr  = '0;
      inst_sram_wdata = '0;
      data_sram_en    = 1'b0;
      data_sram_wen   = 4'b0000;
      data_sram_addr  = '0;
      data_sram_wdata = '0;
      switch          = 8'h3C;
      tick();
      tick();
      check("reset_inst_rdata", inst_sram_rdata, 32'h0);
      check("reset_data_rdata", data_sram_rdata, 32'h0);
      check("reset_led", {16'h0, led}, 32'h0);
      rst = 1'b0;

      data_wr(32'h0000_0000, 32'hCAFE_F00D, 4'hF);

      // Write through kseg0, read back through kseg1 on the other port.
      data_wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
      inst_rd(32'hA000_0010);
      check("kseg_cross_port", inst_sram_rdata, 32'hDEAD_BEEF);

      data_wr(32'h0000_0020, 32'h1122_3344, 4'hF);
      data_wr(32'h0000_0020, 32'hAABB_CCDD, 4'b0101);
      check("read_first_old", data_sram_rdata, 32'h1122_3344);
      data_rd(32'h0000_0020);
      check("byte_lane_merge", data_sram_rdata, 32'h11BB_33DD);

      // Both ports write one word: data wins lanes 1:0, inst keeps lanes 3:2.
      data_sram_en    = 1'b1;
      data_sram_wen   = 4'b0011;
      data_sram_addr  = 32'h0000_0030;
      data_sram_wdata = 32'h0000_5566;
      inst_sram_en    = 1'b1;
      inst_sram_wen   = 4'b1111;
      inst_sram_addr  = 32'h8000_0030;
      inst_sram_wdata = 32'h7788_99AA;
      tick();
      inst_sram_en  = 1'b0;
      inst_sram_wen = 4'b0000;
      data_sram_en  = 1'b0;
      data_sram_wen = 4'b0000;
      data_rd(32'h0000_0030);
      check("dual_write_merge", data_sram_rdata, 32'h7788_5566);

      // Data port reads while the instruction port writes the same word.
      data_sram_en    = 1'b1;
      data_sram_wen   = 4'b0000;
      data_sram_addr  = 32'h0000_0010;
      inst_sram_en    = 1'b1;
      inst_sram_wen   = 4'b1111;
      inst_sram_addr  = 32'h0000_0010;
      inst_sram_wdata = 32'h0102_0304;
      tick();
      inst_sram_en  = 1'b0;
      inst_sram_wen = 4'b0000;
      data_sram_en  = 1'b0;
      check("reader_sees_old", data_sram_rdata, 32'hDEAD_BEEF);
      data_rd(32'h0000_0010);
      check("write_landed", data_sram_rdata, 32'h0102_0304);

      inst_rd(32'h0001_0010);
      check("alias_mod_depth", inst_sram_rdata, 32'h0102_0304);

      // Byte enables with en low must neither write nor update rdata.
      data_sram_en    = 1'b0;
      data_sram_wen   = 4'hF;
      data_sram_addr  = 32'h0000_0010;
      data_sram_wdata = 32'hFFFF_FFFF;
      tick();
      data_sram_wen = 4'b0000;
      check("en_low_hold", data_sram_rdata, 32'h0102_0304);
      data_rd(32'h0000_0010);
      check("en_low_no_write", data_sram_rdata, 32'h0102_0304);

      data_rd(32'hBFAF_0008);
      t0 = data_sram_rdata;
      repeat (9) tick();
      data_rd(32'hBFAF_0008);
      check("timer_delta_10", data_sram_rdata - t0, 32'd10);

      data_wr(32'hBFAF_0008, 32'hFFFF_FFFE, 4'hF);
      data_sram_en   = 1'b1;
      data_sram_wen  = 4'b0000;
      data_sram_addr = 32'hBFAF_0008;
      tick();
      check("timer_load", data_sram_rdata, 32'hFFFF_FFFE);
      tick();
      check("timer_max", data_sram_rdata, 32'hFFFF_FFFF);
      tick();
      check("timer_wrap", data_sram_rdata, 32'h0000_0000);
      data_sram_en = 1'b0;

      data_wr(32'hBFAF_0000, 32'h0000_A5A5, 4'hF);
      check("led_write", {16'h0, led}, 32'h0000_A5A5);
      data_wr(32'hBFAF_0000, 32'h0000_0077, 4'b0001);
      check("led_byte_lane", {16'h0, led}, 32'h0000_A577);
      data_rd(32'hBFAF_0000);
      check("led_readback", data_sram_rdata, 32'h0000_A577);

      data_rd(32'hBFAF_0004);
      check("switch_read", data_sram_rdata, 32'h0000_003C);

      data_wr(32'h9FAF_000C, 32'h1234_5678, 4'hF);
      data_wr(32'hBFAF_000C, 32'hAB00_0000, 4'b1000);
      data_rd(32'hBFAF_000C);
      check("scratch_merge", data_sram_rdata, 32'hAB34_5678);

      data_rd(32'hBFAF_0010);
      check("mmio_unmapped", data_sram_rdata, 32'h0);

      inst_rd(32'h0000_0000);
      check("mmio_no_ram_touch", inst_sram_rdata, 32'hCAFE_F00D);

      // Reads issued during reset are dropped; RAM survives, timer restarts.
      rst            = 1'b1;
      data_sram_en   = 1'b1;
      data_sram_addr = 32'h0000_0030;
      inst_sram_en   = 1'b1;
      inst_sram_addr = 32'h0000_0030;
      tick();
      rst          = 1'b0;
      inst_sram_en = 1'b0;
      data_sram_en = 1'b0;
      check("rst_data_rdata", data_sram_rdata, 32'h0);
      check("rst_inst_rdata", inst_sram_rdata, 32'h0);
      check("rst_led", {16'h0, led}, 32'h0);
      data_rd(32'hBFAF_0008);
      check("rst_timer_zero", data_sram_rdata, 32'h0);
      inst_sram_en    = 1'b1;
      inst_sram_addr  = 32'h0000_0030;
      data_sram_en    = 1'b1;
      data_sram_addr  = 32'h0000_0000;
      tick();
      inst_sram_en = 1'b0;
      data_sram_en = 1'b0;
      check("ram_kept_inst", inst_sram_rdata, 32'h7788_5566);
      check("ram_kept_data", data_sram_rdata, 32'hCAFE_F00D);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Slave-side model of the core's SRAM-like instruction and data ports: the responder to `inst_sram_*` / `data_sram_*`.
- Contents:
  - one shared byte-writable word RAM, served to both ports;
  - a small MMIO register window on the data port: LED, switch, free-running timer, scratch.
- Sits between the CPU core and the SoC top; used by simulation and FPGA builds as the program/data store.

Parameters:
- ADDR_W, 14, word-index bits of the RAM (depth = 2^ADDR_W words, 64 KB at default)
- MMIO_BASE, 32'h1FAF_0000, physical base of the 64 KB MMIO window (data port only)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- inst_sram_en  in  1  instruction port access strobe
- inst_sram_wen  in  4  byte write enables, instruction port
- inst_sram_addr  in  32  virtual byte address, instruction port
- inst_sram_wdata  in  32  write data, instruction port
- inst_sram_rdata  out  32  read data, instruction port, registered
- data_sram_en  in  1  data port access strobe
- data_sram_wen  in  4  byte write enables, data port
- data_sram_addr  in  32  virtual byte address, data port
- data_sram_wdata  in  32  write data, data port
- data_sram_rdata  out  32  read data, data port, registered
- led  out  16  LED register value
- switch  in  8  board switches, sampled through MMIO

Behaviour:
- Reset (clk edge with rst=1):
  - inst_sram_rdata = 0, data_sram_rdata = 0, led = 0, timer = 0, scratch = 0.
  - RAM contents are not reset.
  - Any read issued in the reset cycle is discarded.
- Address translation, both ports:
  - addr[31:29] = 3'b100 or 3'b101 (kseg0/kseg1) -> phys = {3'b000, addr[28:0]};
  - otherwise phys = addr.
  - RAM word index = phys[ADDR_W+1:2]; upper bits are ignored, so out-of-range addresses alias modulo the depth.
- Region decode:
  - data port: phys[31:16] == MMIO_BASE[31:16] -> MMIO; else RAM.
  - instruction port: always RAM.
- Read:
  - en=1 and wen=0 at edge N -> rdata holds the word at edge N+1. Latency is exactly 1 cycle.
  - en=0 -> rdata holds its previous value.
- Write:
  - en=1 and wen!=0: for each lane i with wen[i]=1, byte i (bits 8i+7:8i) is written at the edge.
  - The port's rdata still updates with the pre-write (old) word (read-first).
- Simultaneous same-word access:
  - both ports writing: data port wins on lanes both enable; other lanes merge.
  - one port reads while the other writes: the reader sees the old word.
- MMIO, offset = phys[15:0]:
  - 0x0000 LED: RW, bits 15:0, byte lanes honoured; reads return {16'b0, led}.
  - 0x0004 SWITCH: RO, {24'b0, switch}; writes ignored.
  - 0x0008 TIMER: RW. Increments by 1 every cycle, wraps 0xFFFF_FFFF -> 0. A write in the same cycle wins: the merged value loads and counting resumes on the next cycle. A read returns the pre-edge value.
  - 0x000C SCRATCH: RW, 32 bits, byte lanes honoured.
  - Other offsets: read 0, writes ignored.
  - MMIO reads have the same 1-cycle latency. MMIO accesses never touch RAM.
- en=0 with wen!=0: no write.

Decomposition:
- Shared package:
  - MMIO offset constants (LED/SWITCH/TIMER/SCRATCH);
  - kseg translation function;
  - a byte-lane merge function (old word, wdata, wen -> new word).
- Sub-module: `sram_resp_mmio`, holding the LED/timer/scratch registers, switch readback and the registered MMIO read mux.
- RAM array and the two port pipelines stay in the top.

Test Plan:
- Data write 0xDEADBEEF, wen=4'hF, addr 0x8000_0010; next cycle inst read addr 0xA000_0010 -> inst_sram_rdata = 0xDEADBEEF one cycle after the read strobe.
- Word preloaded 0x11223344; data write wen=4'b0101, wdata 0xAABBCCDD -> subsequent read 0x11BB33DD; rdata in the write cycle+1 = 0x11223344 (read-first).
- Both ports write the same word in the same cycle:
  - data wen=4'b0011, wdata 0x0000_5566;
  - inst wen=4'b1111, wdata 0x7788_99AA;
  - -> stored 0x7788_5566.
- After reset, read TIMER twice 10 cycles apart -> difference 10. Write TIMER 0xFFFF_FFFE, then read on consecutive cycles -> 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- Write LED 0x0000_A5A5 via 0xBFAF_0000 -> led = 16'hA5A5 next cycle. With switch = 8'h3C, read 0xBFAF_0004 -> 0x0000_003C.
- Read issued then rst asserted the next edge -> both rdata = 0, led = 0, timer restarts at 0; RAM word previously written is still readable after reset.
